exe_stage_mc: RTL and testbench
===============================

Name: exe_stage_mc

Overview:
Parametrised, multi-cycle execute stage for the ARM-style pipeline, successor to the single-cycle execute stage.
- Single-cycle ALU path plus an iterative shift-add multiplier (MUL/MLA).
- Branch-target adder.
- Integrated EXE/MEM output register with valid/ready handshake, so the stage can stall upstream and absorb downstream back-pressure.
- Sits between the ID/EXE register (Val2 already generated upstream) and the MEM stage.

Parameters:
- WORD_WIDTH, 32, datapath width.
- SIGNED_IMM_WIDTH, 24, branch offset width; must be < WORD_WIDTH.
- REG_ADDR_WIDTH, 4, destination register index width.
- MUL_BITS_PER_CYCLE, 4, multiplier bits retired per iteration; must divide WORD_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of in-flight and output-held instruction.
- in_valid  in  1  upstream instruction present.
- in_ready  out  1  stage accepts this cycle.
- mem_read_in, mem_write_in, wb_en_in, b_in, s_in  in  1 each  control bits; s_in = update flags.
- mul_in  in  1  multiply op.
- acc_in  in  1  accumulate op (MLA); only meaningful with mul_in.
- ex_cmd  in  4  ALU command.
- sr_in  in  4  current status {Z,C,N,V}, bit3..bit0.
- val1, val2, val_acc  in  WORD_WIDTH each  Rn, generated operand 2, accumulator (Rd).
- val_rm_in  in  WORD_WIDTH  store data.
- pc_in  in  WORD_WIDTH  PC for the branch target.
- signed_imm  in  SIGNED_IMM_WIDTH  branch offset.
- dst_in  in  REG_ADDR_WIDTH  destination register.
- out_valid  out  1  output register holds a result.
- out_ready  in  1  MEM stage consumes.
- alu_res, val_rm_out, branch_addr  out  WORD_WIDTH each  registered results.
- sr_out  out  4  registered new flags.
- sr_we  out  1  registered: flags should be written (s_in of the instruction).
- mem_read_out, mem_write_out, wb_en_out, b_out  out  1 each  registered control bits.
- dst_out  out  REG_ADDR_WIDTH  registered destination.

Behaviour:
- Reset/flush values:
  - On rst: every output register is 0, out_valid=0, FSM=IDLE, iteration counter=0.
  - rst has priority over flush.
  - flush has the same effect as rst on out_valid and the FSM (aborts the multiply; result discarded); datapath registers may keep stale values.
- in_ready = (state==IDLE) & (!out_valid | out_ready) & !flush.
- Accept = in_valid & in_ready.
- Output register handling:
  - Output register loads when a result is produced.
  - Otherwise out_valid clears when out_ready=1.
  - Holds while out_valid & !out_ready.
- Non-mul op accepted at edge k: result, flags and passthroughs registered at edge k, so out_valid=1 from k+1 (latency 1; back-to-back throughput 1/cycle).
- FSM IDLE -> MUL -> DONE -> IDLE:
  - IDLE, accept with mul_in: latch operands and control; clear product (or load val_acc if acc_in); counter=0; go to MUL.
  - MUL: each cycle, add (val1 * next MUL_BITS_PER_CYCLE bits of val2) shifted into the product; counter++.
  - MUL -> DONE after N=WORD_WIDTH/MUL_BITS_PER_CYCLE iterations.
  - DONE: write the output register when !out_valid | out_ready, then go to IDLE. DONE lasts 1 cycle if the output slot is free.
  - Total: accept at edge k gives out_valid from edge k+N+2 when unstalled. in_ready=0 throughout.
- Arithmetic: all results modulo 2^WORD_WIDTH.
  - MUL result = low WORD_WIDTH bits of val1*val2 (+val_acc).
  - MUL flags: N, Z from the result; C, V copied from sr_in.
- ex_cmd encodings:
  - 0001 MOV = val2; 1001 MVN = ~val2.
  - 0010 ADD (also LDR/STR address); 0011 ADC (+C).
  - 0100 SUB/CMP; 0101 SBC (val1-val2-!C).
  - 0110 AND/TST; 0111 ORR; 1000 EOR.
  - Any other value: result 0, flags = sr_in.
- Flags:
  - C and V are defined for the add/sub group only; logic ops and MOV/MVN keep C and V from sr_in.
  - N = result MSB; Z = (result==0).
- branch_addr = pc_in + sign-extended signed_imm, registered alongside the result.
- sr_in, val_acc, val_rm_in and the control bits are sampled at accept. Later changes while in MUL/DONE have no effect.

Decomposition:
- Package exe_pkg holds:
  - ex_cmd encoding constants;
  - SR bit indices (SR_Z=3, SR_C=2, SR_N=1, SR_V=0);
  - FSM state typedef.
- One natural sub-module: exe_iter_mul (iterative multiplier with start/busy/done). The ALU stays inline.

Test Plan:
- Reset mid-multiply: rst asserted during MUL iteration 3 -> next cycle out_valid=0, in_ready=1, FSM=IDLE, all outputs 0.
- ADD, WORD_WIDTH=32: val1=0x7FFFFFFF, val2=1, s_in=1 -> alu_res=0x80000000, sr_out={Z0,C0,N1,V1}, out_valid exactly 1 cycle after accept.
- Back-to-back SUB, then ORR, with out_ready=1 -> one result per cycle. SUB 5-5 gives Z=1, C=1. ORR gives 0xF0|0x0F=0xFF with C, V from sr_in.
- MLA, MUL_BITS_PER_CYCLE=4: val1=0xFFFFFFFF, val2=3, val_acc=10 -> alu_res=7; out_valid at accept+10 edges; in_ready=0 in between.
- Back-pressure: out_ready=0 for 5 cycles with a result held -> outputs stable, in_ready=0. A MUL finishing meanwhile waits in DONE and loads on the first out_ready=1.
- Branch and flush: pc_in=0x100, signed_imm=0xFFFFFC -> branch_addr=0xFC. flush during MUL -> no result emitted; next instruction accepted the following cycle.

Source files
------------

// File: rtl/exe_stage_mc_pkg.sv
// Shared definitions for the multi-cycle execute stage: ALU command
// encodings, status-register bit positions and the control FSM states.
package exe_pkg;

  // ALU command encodings carried on ex_cmd
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;

  // Status register layout {Z,C,N,V}
  localparam int SR_Z = 3;
  localparam int SR_C = 2;
  localparam int SR_N = 1;
  localparam int SR_V = 0;

  // Control FSM: IDLE accepts work, MUL iterates, DONE waits for the output slot
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } exe_state_t;

endpackage

// File: rtl/exe_stage_mc_if.sv
// Bundle of the execute stage's upstream, downstream and control signals.
//
// Handshake: a transfer happens on a rising edge where both valid and ready
// are high. Upstream: in_valid/in_ready; in_ready never depends on in_valid.
// Downstream: out_valid/out_ready; once out_valid is high the output fields
// stay constant until the edge where out_ready is also high.
// fsm_state and mul_busy are observation-only debug signals.
interface exe_stage_mc_if #(
  parameter int WORD_WIDTH       = 32,
  parameter int SIGNED_IMM_WIDTH = 24,
  parameter int REG_ADDR_WIDTH   = 4
) ();

  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic                        mem_read_in;
  logic                        mem_write_in;
  logic                        wb_en_in;
  logic                        b_in;
  logic                        s_in;
  logic                        mul_in;
  logic                        acc_in;
  logic [3:0]                  ex_cmd;
  logic [3:0]                  sr_in;
  logic [WORD_WIDTH-1:0]       val1;
  logic [WORD_WIDTH-1:0]       val2;
  logic [WORD_WIDTH-1:0]       val_acc;
  logic [WORD_WIDTH-1:0]       val_rm_in;
  logic [WORD_WIDTH-1:0]       pc_in;
  logic [SIGNED_IMM_WIDTH-1:0] signed_imm;
  logic [REG_ADDR_WIDTH-1:0]   dst_in;

  logic                        out_valid;
  logic                        out_ready;
  logic [WORD_WIDTH-1:0]       alu_res;
  logic [WORD_WIDTH-1:0]       val_rm_out;
  logic [WORD_WIDTH-1:0]       branch_addr;
  logic [3:0]                  sr_out;
  logic                        sr_we;
  logic                        mem_read_out;
  logic                        mem_write_out;
  logic                        wb_en_out;
  logic                        b_out;
  logic [REG_ADDR_WIDTH-1:0]   dst_out;

  exe_pkg::exe_state_t         fsm_state;
  logic                        mul_busy;

  // Stage side
  modport slave (
    input  flush, in_valid, mem_read_in, mem_write_in, wb_en_in, b_in, s_in,
           mul_in, acc_in, ex_cmd, sr_in, val1, val2, val_acc, val_rm_in,
           pc_in, signed_imm, dst_in, out_ready,
    output in_ready, out_valid, alu_res, val_rm_out, branch_addr, sr_out,
           sr_we, mem_read_out, mem_write_out, wb_en_out, b_out, dst_out,
           fsm_state, mul_busy
  );

  // Pipeline / environment side
  modport master (
    output flush, in_valid, mem_read_in, mem_write_in, wb_en_in, b_in, s_in,
           mul_in, acc_in, ex_cmd, sr_in, val1, val2, val_acc, val_rm_in,
           pc_in, signed_imm, dst_in, out_ready,
    input  in_ready, out_valid, alu_res, val_rm_out, branch_addr, sr_out,
           sr_we, mem_read_out, mem_write_out, wb_en_out, b_out, dst_out,
           fsm_state, mul_busy
  );

endinterface

// File: rtl/exe_iter_mul.sv
// Iterative shift-add multiplier. Each busy cycle retires BITS_PER_CYCLE
// bits of the multiplier; the multiplicand is pre-shifted so every partial
// product lands directly in the low WIDTH bits of the running sum.
module exe_iter_mul #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  input  logic [WIDTH-1:0] addend,
  output logic [WIDTH-1:0] product,
  output logic             busy,
  output logic             done
);

  localparam int ITERS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = (ITERS > 1) ? $clog2(ITERS) : 1;

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] prod_q;
  logic [WIDTH-1:0] digit;
  logic [WIDTH-1:0] partial;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // Current multiplier digit zero-extended, times the shifted multiplicand
  always_comb begin
    digit                       = '0;
    digit[BITS_PER_CYCLE-1:0]   = mplier_q[BITS_PER_CYCLE-1:0];
    partial                     = mcand_q * digit;
  end

  // done marks the final iteration; product is complete after this edge
  assign done    = busy_q & (cnt_q == CNT_W'(ITERS - 1));
  assign busy    = busy_q;
  assign product = prod_q;

  // Operand latch on start, one accumulate step per busy cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (abort) begin
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= multiplicand;
      mplier_q <= multiplier;
      prod_q   <= addend;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      prod_q   <= prod_q + partial;
      mcand_q  <= mcand_q << BITS_PER_CYCLE;
      mplier_q <= mplier_q >> BITS_PER_CYCLE;
      if (done) begin
        cnt_q  <= '0;
        busy_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/exe_stage_mc.sv
// Multi-cycle execute stage: single-cycle ALU, iterative MUL/MLA, branch
// target adder and an integrated EXE/MEM output register with valid/ready.
module exe_stage_mc
  import exe_pkg::*;
#(
  parameter int WORD_WIDTH         = 32,
  parameter int SIGNED_IMM_WIDTH   = 24,
  parameter int REG_ADDR_WIDTH     = 4,
  parameter int MUL_BITS_PER_CYCLE = 4
) (
  input logic           clk,
  input logic           rst,
  exe_stage_mc_if.slave bus
);

  localparam int W = WORD_WIDTH;

  exe_state_t state_q, state_d;

  logic slot_free, in_ready, accept, accept_alu, accept_mul, load_mul;

  // ALU combinational results
  logic [W-1:0] alu_res_c;
  logic [3:0]   alu_sr_c;
  logic [W:0]   sum_c;
  logic         upd_nz;
  logic [W-1:0] branch_c;

  // Multiplier interface
  logic [W-1:0] mul_addend, mul_product;
  logic         mul_busy, mul_done;

  // Instruction fields held while the multiply runs
  logic                      p_mem_read, p_mem_write, p_wb_en, p_b, p_s;
  logic                      p_c, p_v;
  logic [W-1:0]              p_val_rm, p_branch;
  logic [REG_ADDR_WIDTH-1:0] p_dst;

  // Output register
  logic                      out_valid_q;
  logic [W-1:0]              alu_res_q, val_rm_q, branch_q;
  logic [3:0]                sr_q;
  logic                      sr_we_q, mem_read_q, mem_write_q, wb_en_q, b_q;
  logic [REG_ADDR_WIDTH-1:0] dst_q;

  assign slot_free  = !out_valid_q | bus.out_ready;
  assign in_ready   = (state_q == ST_IDLE) & slot_free & !bus.flush;
  assign accept     = bus.in_valid & in_ready;
  assign accept_alu = accept & !bus.mul_in;
  assign accept_mul = accept & bus.mul_in;
  assign load_mul   = (state_q == ST_DONE) & slot_free & !bus.flush;

  assign branch_c = bus.pc_in
                  + {{(W - SIGNED_IMM_WIDTH){bus.signed_imm[SIGNED_IMM_WIDTH-1]}}, bus.signed_imm};

  assign mul_addend = bus.acc_in ? bus.val_acc : '0;

  exe_iter_mul #(
    .WIDTH          (W),
    .BITS_PER_CYCLE (MUL_BITS_PER_CYCLE)
  ) u_mul (
    .clk          (clk),
    .rst          (rst),
    .abort        (bus.flush),
    .start        (accept_mul),
    .multiplicand (bus.val1),
    .multiplier   (bus.val2),
    .addend       (mul_addend),
    .product      (mul_product),
    .busy         (mul_busy),
    .done         (mul_done)
  );

  // Single-cycle ALU; C/V only change for the add/sub group
  always_comb begin
    alu_res_c = '0;
    alu_sr_c  = bus.sr_in;
    sum_c     = '0;
    upd_nz    = 1'b1;
    case (bus.ex_cmd)
      CMD_MOV: alu_res_c = bus.val2;
      CMD_MVN: alu_res_c = ~bus.val2;
      CMD_ADD, CMD_ADC: begin
        sum_c = {1'b0, bus.val1} + {1'b0, bus.val2}
              + {{W{1'b0}}, (bus.ex_cmd == CMD_ADC) & bus.sr_in[SR_C]};
        alu_res_c      = sum_c[W-1:0];
        alu_sr_c[SR_C] = sum_c[W];
        alu_sr_c[SR_V] = (bus.val1[W-1] == bus.val2[W-1]) & (sum_c[W-1] != bus.val1[W-1]);
      end
      CMD_SUB, CMD_SBC: begin
        // a - b - borrow computed as a + ~b + carry, ARM carry = not-borrow
        sum_c = {1'b0, bus.val1} + {1'b0, ~bus.val2}
              + {{W{1'b0}}, (bus.ex_cmd == CMD_SUB) | bus.sr_in[SR_C]};
        alu_res_c      = sum_c[W-1:0];
        alu_sr_c[SR_C] = sum_c[W];
        alu_sr_c[SR_V] = (bus.val1[W-1] != bus.val2[W-1]) & (sum_c[W-1] != bus.val1[W-1]);
      end
      CMD_AND: alu_res_c = bus.val1 & bus.val2;
      CMD_ORR: alu_res_c = bus.val1 | bus.val2;
      CMD_EOR: alu_res_c = bus.val1 ^ bus.val2;
      default: upd_nz = 1'b0;
    endcase
    if (upd_nz) begin
      alu_sr_c[SR_N] = alu_res_c[W-1];
      alu_sr_c[SR_Z] = (alu_res_c == '0);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; flush aborts whatever is in flight
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_mul) state_d = ST_MUL;
      ST_MUL:  if (mul_done)   state_d = ST_DONE;
      ST_DONE: if (slot_free)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (bus.flush) state_d = ST_IDLE;
  end

  // Capture the multiply's non-arithmetic fields at accept
  always_ff @(posedge clk) begin
    if (rst) begin
      p_mem_read  <= 1'b0;
      p_mem_write <= 1'b0;
      p_wb_en     <= 1'b0;
      p_b         <= 1'b0;
      p_s         <= 1'b0;
      p_c         <= 1'b0;
      p_v         <= 1'b0;
      p_val_rm    <= '0;
      p_branch    <= '0;
      p_dst       <= '0;
    end else if (accept_mul) begin
      p_mem_read  <= bus.mem_read_in;
      p_mem_write <= bus.mem_write_in;
      p_wb_en     <= bus.wb_en_in;
      p_b         <= bus.b_in;
      p_s         <= bus.s_in;
      p_c         <= bus.sr_in[SR_C];
      p_v         <= bus.sr_in[SR_V];
      p_val_rm    <= bus.val_rm_in;
      p_branch    <= branch_c;
      p_dst       <= bus.dst_in;
    end
  end

  // EXE/MEM output register: load on a produced result, else drain on out_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      alu_res_q   <= '0;
      val_rm_q    <= '0;
      branch_q    <= '0;
      sr_q        <= '0;
      sr_we_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      wb_en_q     <= 1'b0;
      b_q         <= 1'b0;
      dst_q       <= '0;
    end else begin
      if (bus.flush)                  out_valid_q <= 1'b0;
      else if (accept_alu | load_mul) out_valid_q <= 1'b1;
      else if (bus.out_ready)         out_valid_q <= 1'b0;

      if (accept_alu) begin
        alu_res_q   <= alu_res_c;
        sr_q        <= alu_sr_c;
        val_rm_q    <= bus.val_rm_in;
        branch_q    <= branch_c;
        sr_we_q     <= bus.s_in;
        mem_read_q  <= bus.mem_read_in;
        mem_write_q <= bus.mem_write_in;
        wb_en_q     <= bus.wb_en_in;
        b_q         <= bus.b_in;
        dst_q       <= bus.dst_in;
      end else if (load_mul) begin
        alu_res_q   <= mul_product;
        sr_q        <= {(mul_product == '0), p_c, mul_product[W-1], p_v};
        val_rm_q    <= p_val_rm;
        branch_q    <= p_branch;
        sr_we_q     <= p_s;
        mem_read_q  <= p_mem_read;
        mem_write_q <= p_mem_write;
        wb_en_q     <= p_wb_en;
        b_q         <= p_b;
        dst_q       <= p_dst;
      end
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.alu_res       = alu_res_q;
  assign bus.val_rm_out    = val_rm_q;
  assign bus.branch_addr   = branch_q;
  assign bus.sr_out        = sr_q;
  assign bus.sr_we         = sr_we_q;
  assign bus.mem_read_out  = mem_read_q;
  assign bus.mem_write_out = mem_write_q;
  assign bus.wb_en_out     = wb_en_q;
  assign bus.b_out         = b_q;
  assign bus.dst_out       = dst_q;
  assign bus.fsm_state     = state_q;
  assign bus.mul_busy      = mul_busy;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Bench for exe_stage_mc: directed scenarios plus random traffic, checked by
// a scoreboard fed from an arithmetic reference model.
module tb_exe_stage_mc;
  import exe_pkg::*;

  localparam int W   = 32;
  localparam int SIW = 24;
  localparam int RAW = 4;
  localparam int BPC = 4;
  localparam int N   = W / BPC;
  localparam int EW  = 3 * W + 4 + 1 + 4 + RAW;

  typedef struct {
    logic           mul, acc, mr, mw, wb, b, s;
    logic [3:0]     cmd, sr;
    logic [W-1:0]   v1, v2, vacc, vrm, pc;
    logic [SIW-1:0] imm;
    logic [RAW-1:0] dst;
  } op_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   rdy_mode = 0;
  logic [EW-1:0] exp_q[$];

  exe_stage_mc_if #(.WORD_WIDTH(W), .SIGNED_IMM_WIDTH(SIW), .REG_ADDR_WIDTH(RAW)) bus ();

  exe_stage_mc #(
    .WORD_WIDTH(W), .SIGNED_IMM_WIDTH(SIW), .REG_ADDR_WIDTH(RAW), .MUL_BITS_PER_CYCLE(BPC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic bit ovf(input longint x);
    return (x >= (longint'(1) << (W - 1))) || (x < -(longint'(1) << (W - 1)));
  endfunction

  function automatic logic [EW-1:0] model(input op_t o);
    longint unsigned ua, ub, r, mask, br;
    longint sa, sb, off;
    logic z, c, n, v, cin;
    int unsigned bw;
    bit nz;
    mask = (64'd1 << W) - 64'd1;
    ua = o.v1; ub = o.v2;
    sa = longint'($signed(o.v1)); sb = longint'($signed(o.v2));
    z = o.sr[SR_Z]; c = o.sr[SR_C]; n = o.sr[SR_N]; v = o.sr[SR_V];
    cin = c; bw = cin ? 0 : 1; nz = 1; r = 0;
    if (o.mul) begin
      r = ua * ub;
      if (o.acc) r = r + o.vacc;
    end else begin
      case (o.cmd)
        4'd1: r = ub;
        4'd9: r = ~ub;
        4'd2: begin r = ua + ub;       c = (r > mask); v = ovf(sa + sb); end
        4'd3: begin r = ua + ub + cin; c = (r > mask); v = ovf(sa + sb + cin); end
        4'd4: begin c = (ua >= ub);      r = ua - ub;      v = ovf(sa - sb); end
        4'd5: begin c = (ua >= ub + bw); r = ua - ub - bw; v = ovf(sa - sb - bw); end
        4'd6: r = ua & ub;
        4'd7: r = ua | ub;
        4'd8: r = ua ^ ub;
        default: begin r = 0; nz = 0; end
      endcase
    end
    r = r & mask;
    if (nz) begin n = r[W-1]; z = (r == 0); end
    off = longint'($signed(o.imm));
    br  = (longint'(o.pc) + off) & mask;
    return {r[W-1:0], o.vrm, br[W-1:0], {z, c, n, v}, o.s, o.mr, o.mw, o.wb, o.b, o.dst};
  endfunction

  function automatic logic [EW-1:0] actual();
    return {bus.alu_res, bus.val_rm_out, bus.branch_addr, bus.sr_out, bus.sr_we,
            bus.mem_read_out, bus.mem_write_out, bus.wb_en_out, bus.b_out, bus.dst_out};
  endfunction

  function automatic op_t blank_op();
    op_t o;
    o.mul = 0; o.acc = 0; o.mr = 0; o.mw = 0; o.wb = 1; o.b = 0; o.s = 1;
    o.cmd = 4'd0; o.sr = 4'd0; o.v1 = '0; o.v2 = '0; o.vacc = '0;
    o.vrm = 32'h1234_5678; o.pc = 32'h0000_0400; o.imm = 24'h000010; o.dst = 4'd3;
    return o;
  endfunction

  function automatic logic [W-1:0] rand_word();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t o;
    o.mul = ($urandom_range(0, 3) == 0); o.acc = $urandom_range(0, 1);
    o.mr = $urandom_range(0, 1); o.mw = $urandom_range(0, 1);
    o.wb = $urandom_range(0, 1); o.b = $urandom_range(0, 1); o.s = $urandom_range(0, 1);
    o.cmd = 4'($urandom_range(0, 15)); o.sr = 4'($urandom_range(0, 15));
    o.v1 = rand_word(); o.v2 = rand_word(); o.vacc = rand_word();
    o.vrm = $urandom; o.pc = $urandom; o.imm = SIW'($urandom); o.dst = RAW'($urandom);
    return o;
  endfunction

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input op_t o);
    bus.mul_in = o.mul; bus.acc_in = o.acc; bus.mem_read_in = o.mr;
    bus.mem_write_in = o.mw; bus.wb_en_in = o.wb; bus.b_in = o.b; bus.s_in = o.s;
    bus.ex_cmd = o.cmd; bus.sr_in = o.sr; bus.val1 = o.v1; bus.val2 = o.v2;
    bus.val_acc = o.vacc; bus.val_rm_in = o.vrm; bus.pc_in = o.pc;
    bus.signed_imm = o.imm; bus.dst_in = o.dst;
  endtask

  // Call just after a falling edge; returns #1 after the accepting edge
  task automatic issue(input op_t o, input bit push, output int acc_cyc);
    int tries;
    tries = 0; acc_cyc = -1;
    drive(o);
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && tries < 300) begin
      @(negedge clk); #1; tries++;
    end
    if (!bus.in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL issue_timeout: in_ready %0b, expected 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back(model(o));
    @(posedge clk); #1;
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
    drive(rand_op());
  endtask

  // Falling edges until out_valid; optionally checks in_ready stays low meanwhile
  task automatic wait_valid(input bit check_busy, output int n);
    n = 0;
    do begin
      @(negedge clk); n++;
      if (!bus.out_valid && check_busy) check("in_ready_busy", 128'(bus.in_ready), 128'(0));
    end while (!bus.out_valid && n < 100);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 500) begin @(negedge clk); k++; end
    check("drain_empty", 128'(exp_q.size()), 128'(0));
  endtask

  // ---------------- downstream ready generator ----------------
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (rst !== 1'b1 && bus.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_out: alu_res %0h with no expected result", bus.alu_res);
      end else begin
        check("result", 128'(actual()), 128'(exp_q[0]));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    op_t o;
    int  k, k2, n, f;
    rst = 1'b1; bus.flush = 1'b0; bus.in_valid = 1'b0;
    drive(blank_op());

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_state", 128'(bus.fsm_state), 128'(ST_IDLE));
    check("rst_outputs", 128'(actual()), 128'(0));
    rst = 1'b0;

    // ADD overflow, latency 1
    @(negedge clk);
    o = blank_op(); o.cmd = CMD_ADD; o.v1 = 32'h7FFF_FFFF; o.v2 = 32'h1;
    issue(o, 1, k);
    wait_valid(0, n);
    check("add_latency", 128'(n), 128'(1));
    check("add_res", 128'(bus.alu_res), 128'(32'h8000_0000));
    check("add_flags", 128'(bus.sr_out), 128'(4'b0011));

    // Back-to-back SUB then ORR
    @(negedge clk);
    o = blank_op(); o.cmd = CMD_SUB; o.v1 = 32'd5; o.v2 = 32'd5;
    issue(o, 1, k);
    @(negedge clk);
    o = blank_op(); o.cmd = CMD_ORR; o.v1 = 32'hF0; o.v2 = 32'h0F; o.sr = 4'b0101;
    issue(o, 1, k2);
    check("b2b_throughput", 128'(k2 - k), 128'(1));
    @(negedge clk);
    check("orr_res", 128'(bus.alu_res), 128'(32'hFF));
    check("orr_flags", 128'(bus.sr_out), 128'(4'b0101));
    drain();

    // MLA latency and value
    @(negedge clk);
    o = blank_op(); o.mul = 1; o.acc = 1;
    o.v1 = 32'hFFFF_FFFF; o.v2 = 32'd3; o.vacc = 32'd10;
    issue(o, 1, k);
    wait_valid(1, n);
    check("mla_latency", 128'(n), 128'(N + 2));
    check("mla_res", 128'(bus.alu_res), 128'(7));
    drain();

    // Back-pressure: held result, then a MUL completing under out_ready=0
    rdy_mode = 2;
    @(negedge clk); @(negedge clk);
    o = blank_op(); o.cmd = CMD_EOR; o.v1 = 32'hA5A5_0000; o.v2 = 32'h0000_5A5A;
    issue(o, 1, k);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_held", 128'(bus.out_valid), 128'(1));
      check("bp_in_ready", 128'(bus.in_ready), 128'(0));
    end
    rdy_mode = 0;
    @(negedge clk);
    o = blank_op(); o.mul = 1; o.v1 = 32'd1234; o.v2 = 32'd5678; o.sr = 4'b0111;
    issue(o, 1, k);
    rdy_mode = 2;
    wait_valid(1, n);
    check("bp_mul_latency", 128'(n), 128'(N + 2));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_mul_held", 128'(bus.out_valid), 128'(1));
    end
    rdy_mode = 0;
    drain();

    // Branch target with negative offset
    @(negedge clk);
    o = blank_op(); o.cmd = CMD_MOV; o.pc = 32'h100; o.imm = 24'hFFFFFC; o.b = 1;
    issue(o, 1, k);
    @(negedge clk);
    check("branch_addr", 128'(bus.branch_addr), 128'(32'hFC));
    drain();

    // Flush during MUL: no result, next instruction accepted the following cycle
    @(negedge clk);
    o = blank_op(); o.mul = 1; o.v1 = 32'd77; o.v2 = 32'd99;
    issue(o, 0, k);
    repeat (3) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    f = cyc;
    #1;
    check("flush_state", 128'(bus.fsm_state), 128'(ST_IDLE));
    check("flush_in_ready", 128'(bus.in_ready), 128'(1));
    o = blank_op(); o.cmd = CMD_AND; o.v1 = 32'hFFFF_0F0F; o.v2 = 32'h0F0F_FFFF;
    issue(o, 1, k);
    check("flush_next_accept", 128'(k - f), 128'(1));
    repeat (N + 4) @(negedge clk);
    drain();

    // Reset in the middle of a multiply
    @(negedge clk);
    o = blank_op(); o.mul = 1; o.v1 = 32'hDEAD; o.v2 = 32'hBEEF;
    issue(o, 0, k);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("rst_mid_out_valid", 128'(bus.out_valid), 128'(0));
    check("rst_mid_in_ready", 128'(bus.in_ready), 128'(1));
    check("rst_mid_state", 128'(bus.fsm_state), 128'(ST_IDLE));
    check("rst_mid_outputs", 128'(actual()), 128'(0));
    rst = 1'b0;

    // Random traffic with random back-pressure
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      issue(rand_op(), 1, k);
    end
    rdy_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
